// File: rtl/lift_pkg.sv
// lift_pkg: shared floor type, car state encoding and default timing constants
package lift_pkg;
  localparam int FLOOR_W_DEF = 4;
  localparam int TRAVEL_CYCLES_DEF = 8;
  localparam int DOOR_CYCLES_DEF = 4;
  typedef logic [FLOOR_W_DEF-1:0] floor_t;
  typedef enum logic [2:0] {IDLE, MOVE_PICK, DOOR_PICK, MOVE_DEST, DOOR_DEST} car_state_t;
endpackage

// File: rtl/lift_car_ctrl_if.sv
// lift_car_ctrl_if: dispatcher <-> car job and status bundle; door_hold exists only with LIFT_DOOR_HOLD_EN
interface lift_car_ctrl_if #(parameter int FLOOR_W = 4);
  logic req_valid;
  logic req_ready;
  logic [FLOOR_W-1:0] req_pickup;
  logic [FLOOR_W-1:0] req_dest;
  logic req_err;
  logic [FLOOR_W-1:0] cur_floor;
  logic [FLOOR_W-1:0] target_floor;
  logic moving;
  logic dir_up;
  logic busy;
  logic door_open;
  logic done;
`ifdef LIFT_DOOR_HOLD_EN
  logic door_hold;
  modport master (output req_valid, req_pickup, req_dest, door_hold,
                  input req_ready, req_err, cur_floor, target_floor, moving, dir_up, busy, door_open, done);
  modport slave (input req_valid, req_pickup, req_dest, door_hold,
                 output req_ready, req_err, cur_floor, target_floor, moving, dir_up, busy, door_open, done);
`else
  modport master (output req_valid, req_pickup, req_dest,
                  input req_ready, req_err, cur_floor, target_floor, moving, dir_up, busy, door_open, done);
  modport slave (input req_valid, req_pickup, req_dest,
                 output req_ready, req_err, cur_floor, target_floor, moving, dir_up, busy, door_open, done);
`endif
endinterface

// File: rtl/lift_tick_counter.sv
// lift_tick_counter: reloadable down-counter shared by travel and door timing
module lift_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero = cnt_q == '0;
  // load wins; otherwise count down and park at zero
  always_comb cnt_d = load ? load_val : (en && !zero) ? cnt_q - 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/lift_car_ctrl.sv
// lift_car_ctrl: per-car job executor (pickup, door, dest, door); optional LIFT_DOOR_HOLD_EN adds door_hold
module lift_car_ctrl
  import lift_pkg::*;
#(
  parameter int FLOOR_W = 4,
  parameter int NUM_FLOORS = 16,
  parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
  input logic clk,
  input logic rst_n,
  lift_car_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2((TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TRAV1 = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR1 = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W:0] NF = (FLOOR_W + 1)'(NUM_FLOORS);
  car_state_t state_q, state_d;
  logic [FLOOR_W-1:0] cur_q, cur_d, tgt_q, tgt_d, dest_q, dest_d, nxt;
  logic dir_q, dir_d, moving_q, moving_d, busy_q, busy_d, door_q, door_d, done_q, done_d, err_q, err_d;
  logic ld, en, zero, hold;
  logic [CNT_W-1:0] ld_val;
`ifdef LIFT_DOOR_HOLD_EN
  assign hold = bus.door_hold;
`else
  assign hold = 1'b0;
`endif
  assign nxt = dir_q ? cur_q + 1'b1 : cur_q - 1'b1;
  assign en = state_q != IDLE;
  lift_tick_counter #(.W(CNT_W)) u_tick (
    .clk(clk), .rst_n(rst_n), .load(ld), .load_val(ld_val), .en(en), .zero(zero)
  );
  // next-state, counter reloads and registered output values
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    tgt_d = tgt_q;
    dest_d = dest_q;
    dir_d = dir_q;
    err_d = 1'b0;
    ld = 1'b0;
    ld_val = TRAV1;
    unique case (state_q)
      IDLE:
        if (bus.req_valid) begin
          if ({1'b0, bus.req_pickup} >= NF || {1'b0, bus.req_dest} >= NF) err_d = 1'b1;
          else begin
            dest_d = bus.req_dest;
            tgt_d = bus.req_pickup;
            ld = 1'b1;
            if (bus.req_pickup == cur_q) begin
              state_d = DOOR_PICK;
              ld_val = DOOR1;
            end else begin
              state_d = MOVE_PICK;
              dir_d = bus.req_pickup > cur_q;
            end
          end
        end
      MOVE_PICK, MOVE_DEST:
        if (zero) begin
          cur_d = nxt;
          ld = 1'b1;
          if (nxt == tgt_q) begin
            state_d = state_q == MOVE_PICK ? DOOR_PICK : DOOR_DEST;
            ld_val = DOOR1;
          end
        end
      DOOR_PICK, DOOR_DEST:
        if (hold) begin
          ld = 1'b1;
          ld_val = DOOR1;
        end else if (zero) begin
          if (state_q == DOOR_DEST) state_d = IDLE;
          else begin
            tgt_d = dest_q;
            ld = 1'b1;
            if (dest_q == cur_q) begin
              state_d = DOOR_DEST;
              ld_val = DOOR1;
            end else begin
              state_d = MOVE_DEST;
              dir_d = dest_q > cur_q;
            end
          end
        end
    endcase
    moving_d = state_d == MOVE_PICK || state_d == MOVE_DEST;
    door_d = state_d == DOOR_PICK || state_d == DOOR_DEST;
    busy_d = state_d != IDLE;
    done_d = state_q == DOOR_DEST && state_d == IDLE;
  end
  // state and output registers; reset aborts any job and parks the car at floor 0
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q <= '0;
      tgt_q <= '0;
      dest_q <= '0;
      dir_q <= 1'b0;
      moving_q <= 1'b0;
      busy_q <= 1'b0;
      door_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      tgt_q <= tgt_d;
      dest_q <= dest_d;
      dir_q <= dir_d;
      moving_q <= moving_d;
      busy_q <= busy_d;
      door_q <= door_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign bus.req_ready = state_q == IDLE;
  assign bus.req_err = err_q;
  assign bus.cur_floor = cur_q;
  assign bus.target_floor = tgt_q;
  assign bus.moving = moving_q;
  assign bus.dir_up = dir_q;
  assign bus.busy = busy_q;
  assign bus.door_open = door_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_lift_car_ctrl.sv
// tb_lift_car_ctrl: directed checks of lift_car_ctrl with TRAVEL=4, DOOR=3, NUM_FLOORS=10
module tb_lift_car_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int fails = 0;
  int dc, mc, da, dn, ef;
  lift_car_ctrl_if #(.FLOOR_W(4)) bus ();
  lift_car_ctrl #(.FLOOR_W(4), .NUM_FLOORS(10), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept(input logic [3:0] p, input logic [3:0] d);
    bus.req_valid = 1'b1;
    bus.req_pickup = p;
    bus.req_dest = d;
    nxt();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_pickup = '0;
    bus.req_dest = '0;
`ifdef LIFT_DOOR_HOLD_EN
    bus.door_hold = 1'b0;
`endif
    @(negedge clk);
    nxt();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_cur", bus.cur_floor, 0);
    chk("rst_tgt", bus.target_floor, 0);
    chk("rst_moving", bus.moving, 0);
    chk("rst_dir", bus.dir_up, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_door", bus.door_open, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.req_err, 0);
    rst_n = 1'b1;
    nxt();
    // full job 0 -> 3 -> 1
    accept(3, 1);
    dc = 0; dn = 0; da = 0;
    for (int c = 1; c <= 30; c++) begin
      ef = c < 5 ? 0 : c < 9 ? 1 : c < 13 ? 2 : c < 20 ? 3 : c < 24 ? 2 : 1;
      chk("full_cur", bus.cur_floor, ef);
      if (c == 2) begin
        chk("full_up_moving", bus.moving, 1);
        chk("full_up_dir", bus.dir_up, 1);
        chk("full_up_tgt", bus.target_floor, 3);
        chk("full_ready_low", bus.req_ready, 0);
        chk("full_busy", bus.busy, 1);
      end
      if (c == 14) chk("full_pick_moving", bus.moving, 0);
      if (c == 17) begin
        chk("full_dn_moving", bus.moving, 1);
        chk("full_dn_dir", bus.dir_up, 0);
        chk("full_dn_tgt", bus.target_floor, 1);
      end
      if (c == 27) begin
        chk("full_end_busy", bus.busy, 0);
        chk("full_end_ready", bus.req_ready, 1);
        chk("full_end_dir", bus.dir_up, 0);
      end
      dc += int'(bus.door_open);
      dn += int'(bus.done);
      if (bus.done && da == 0) da = c;
      nxt();
    end
    chk("full_door_cycles", dc, 6);
    chk("full_done_at", da, 27);
    chk("full_done_pulses", dn, 1);
    // 1 -> 2 with a request offered mid-travel
    accept(2, 2);
    dc = 0; da = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        chk("busy_ready_low", bus.req_ready, 0);
        bus.req_valid = 1'b1;
        bus.req_pickup = 5;
        bus.req_dest = 7;
      end
      if (c == 3) bus.req_valid = 1'b0;
      chk("busy_cur", bus.cur_floor, c < 5 ? 1 : 2);
      if (c == 12) begin
        chk("busy_tgt", bus.target_floor, 2);
        chk("busy_idle", bus.busy, 0);
      end
      dc += int'(bus.door_open);
      if (bus.done && da == 0) da = c;
      nxt();
    end
    chk("busy_door_cycles", dc, 6);
    chk("busy_done_at", da, 11);
    // same-floor pickup and dest at floor 2
    accept(2, 2);
    dc = 0; mc = 0; da = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) chk("same_door_first", bus.door_open, 1);
      dc += int'(bus.door_open);
      mc += int'(bus.moving);
      if (bus.done && da == 0) da = c;
      nxt();
    end
    chk("same_door_cycles", dc, 6);
    chk("same_moving", mc, 0);
    chk("same_done_at", da, 7);
    chk("same_cur", bus.cur_floor, 2);
    // out-of-range pickup, then out-of-range dest
    accept(12, 3);
    chk("oor_err", bus.req_err, 1);
    chk("oor_busy", bus.busy, 0);
    chk("oor_ready", bus.req_ready, 1);
    chk("oor_tgt", bus.target_floor, 2);
    chk("oor_cur", bus.cur_floor, 2);
    nxt();
    chk("oor_err_pulse", bus.req_err, 0);
    chk("oor_still_idle", bus.busy, 0);
    accept(3, 15);
    chk("oor_dest_err", bus.req_err, 1);
    chk("oor_dest_busy", bus.busy, 0);
    nxt();
    chk("oor_dest_pulse", bus.req_err, 0);
    // reset during MOVE_DEST at floor 2 (2 -> 3 -> 0)
    accept(3, 0);
    for (int c = 1; c < 12; c++) nxt();
    chk("mid_cur", bus.cur_floor, 2);
    chk("mid_moving", bus.moving, 1);
    chk("mid_dir", bus.dir_up, 0);
    rst_n = 1'b0;
    nxt();
    chk("mid_rst_cur", bus.cur_floor, 0);
    chk("mid_rst_ready", bus.req_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_moving", bus.moving, 0);
    chk("mid_rst_tgt", bus.target_floor, 0);
    rst_n = 1'b1;
    nxt();
`ifdef LIFT_DOOR_HOLD_EN
    bus.door_hold = 1'b1;
    accept(0, 1);
    dc = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 6) bus.door_hold = 1'b0;
      if (c == 9) chk("hold_moving", bus.moving, 1);
      dc += int'(bus.door_open);
      nxt();
    end
    chk("hold_door_cycles", dc, 8);
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/lift_car_ctrl.md
# lift_car_ctrl

Per-car motion controller that executes one dispatcher job: travel to the pickup floor, open the door, travel to the destination floor, and open the door again. One instance sits behind each car. It reports position, direction, motion and busy status back to the lift dispatcher, which uses them for its step-cost comparison. Floor travel and door dwell are modelled as cycle counts.

## Interface
- `FLOOR_W`, default 4: floor index width.
- `NUM_FLOORS`, default 16: number of valid floors, 0 to NUM_FLOORS-1.
- `TRAVEL_CYCLES`, default 8: clock cycles to move one floor. Must be at least 1.
- `DOOR_CYCLES`, default 4: clock cycles the door stays open. Must be at least 1.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `req_valid`, in, 1: job offered.
- `req_ready`, out, 1: controller can accept a job.
- `req_pickup`, in, FLOOR_W: pickup floor.
- `req_dest`, in, FLOOR_W: destination floor.
- `req_err`, out, 1: one-cycle pulse when an accepted job is rejected.
- `cur_floor`, out, FLOOR_W: current car floor.
- `target_floor`, out, FLOOR_W: floor the car is heading to.
- `moving`, out, 1: car is between floors.
- `dir_up`, out, 1: current or last direction; 1 = up.
- `busy`, out, 1: job in progress.
- `door_open`, out, 1: door is open.
- `done`, out, 1: one-cycle pulse when the job completes.
- `door_hold`, in, 1: only present with `LIFT_DOOR_HOLD_EN`.

## Operation
- Five states: IDLE, MOVE_PICK, DOOR_PICK, MOVE_DEST, DOOR_DEST.
- `req_ready` = (state == IDLE). It is combinational from state.
- A transfer occurs on a rising edge with `req_valid && req_ready`.
- Accepted job with either floor ≥ NUM_FLOORS:
  - pulse `req_err` next cycle;
  - stay in IDLE;
  - no other output changes.
- Accepted valid job:
  - latch pickup and dest;
  - `busy` = 1;
  - `target_floor` = pickup;
  - if pickup == `cur_floor`, go to DOOR_PICK; otherwise go to MOVE_PICK.
- MOVE_x states:
  - `moving` = 1;
  - `dir_up` = (target > `cur_floor`);
  - the tick counter loads TRAVEL_CYCLES-1;
  - at counter 0, `cur_floor` steps ±1 by exactly one floor;
  - if the new floor equals target, enter DOOR_x; otherwise reload.
- DOOR_PICK:
  - `door_open` = 1 for DOOR_CYCLES cycles;
  - then `target_floor` = dest;
  - if dest == `cur_floor`, go to DOOR_DEST; otherwise go to MOVE_DEST.
- DOOR_DEST: `door_open` for DOOR_CYCLES cycles, then IDLE. `done` pulses in the first IDLE cycle and `busy` falls in that same cycle.
- `dir_up` holds its last value in IDLE and DOOR states.
- `req_valid` while not ready is ignored; there is no queuing.
- `cur_floor` never wraps; out-of-range floors are rejected at acceptance.
- Reset values: state IDLE and `req_ready` = 1. All other outputs are 0, including `cur_floor`, `target_floor`, `dir_up`, `moving`, `busy`, `door_open`, `done` and `req_err`.
- Reset mid-job aborts the job. The car position re-initialises to floor 0 on the same edge.

## Timing
- Acceptance to first floor step: TRAVEL_CYCLES cycles.
- Acceptance to `door_open` when pickup == `cur_floor`: 1 cycle.
- Full job latency, acceptance edge to `done` pulse: (|cur−pickup| + |pickup−dest|) × TRAVEL_CYCLES + 2 × DOOR_CYCLES + 1 cycles.
- `req_ready` reasserts in the same cycle as `done`. A new job can be accepted on the next edge.

## Configuration
- `LIFT_DOOR_HOLD_EN`:
  - **Defined:** the `door_hold` port exists. While it is high in a DOOR state, the door counter reloads DOOR_CYCLES-1, so the door stays open until DOOR_CYCLES cycles after release.
  - **Undefined:** the port is absent and the dwell is fixed.

## Structure
- Package `lift_pkg`:
  - `floor_t` typedef;
  - `car_state_t` enum with the five states;
  - default TRAVEL/DOOR constants.
- Sub-module `lift_tick_counter`:
  - reloadable down-counter;
  - inputs `load`, `load_val`, `en`;
  - output `zero`;
  - shared for travel and door timing.

## Test plan
All scenarios use TRAVEL_CYCLES = 4 and DOOR_CYCLES = 3.
- **Reset:** hold `rst_n` = 0 for 2 cycles. Expect all outputs 0 and `req_ready` = 1.
- **Full job:** from floor 0, send pickup = 3, dest = 1.
  - `cur_floor` steps 1, 2, 3 every 4 cycles with `dir_up` = 1.
  - `door_open` is high for 3 cycles.
  - `cur_floor` steps 2, 1 with `dir_up` = 0, then the door opens for 3 cycles.
  - `done` pulses 27 cycles after acceptance.
- **Same-floor pickup:** at floor 2, send pickup = 2, dest = 2. Expect `door_open` 1 cycle after acceptance, 6 door cycles total, `done` at cycle 7, and `moving` never 1.
- **Out-of-range:** with NUM_FLOORS = 10, send pickup = 12. Expect a single `req_err` pulse, state stays IDLE, and `busy` stays 0.
- **Busy:** pulse `req_valid` mid-travel. Expect `req_ready` = 0 and the job ignored; the original job completes unchanged.
- **Reset mid-travel and door hold:**
  - `rst_n` low at floor 2 during MOVE_DEST returns the controller to IDLE at floor 0 next edge.
  - With `LIFT_DOOR_HOLD_EN`, holding `door_hold` for 5 cycles gives 8 door cycles.
